toeplitz_sum_single: RTL and testbench
======================================

Name: toeplitz_sum_single

Overview:
- Consumer end of the Toeplitz row stream produced by the seed-shift block.
- Latches one raw data block and requests rows from the generator. For each valid row, XOR-accumulates the row into a ROW_W-bit hash when the matching raw bit (MSB first) is 1.
- After ROWS rows, presents the hashed key with a valid/ready handshake toward downstream storage.

Parameters:
- ROW_W, 3072: width of each Toeplitz row and of the output key.
- ROWS, 4096: rows consumed per block; equals the raw data block width.
- CNT_W, 13: row counter width; must satisfy 2^CNT_W >= ROWS.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- raw_data  input  ROWS  raw key block, MSB consumed first.
- data_en  input  1  raw_data valid request.
- data_ack  output  1  one-cycle pulse when raw_data is latched.
- shift_en  output  1  row request to the generator; high while accumulating.
- row_valid  input  1  shift_row holds a new row this cycle.
- shift_row  input  ROW_W  current Toeplitz row.
- key_out  output  ROW_W  hashed key; registered and held.
- key_valid  output  1  key_out valid; held until key_ready.
- key_ready  input  1  downstream accepts key.
- busy  output  1  high in ACC or DONE.

Behaviour:
- Reset (async, any state): all outputs are 0; acc, data_cache and row_cnt are cleared; state goes to IDLE. A reset mid-block discards the partial hash, and no key_valid is produced for that block.
- States: IDLE, ACC, DONE. Any other encoding returns to IDLE.
- IDLE:
  - acc=0, row_cnt=0, key_valid=0, shift_en=0.
  - If data_en: data_cache<=raw_data, data_ack<=1 for exactly one cycle, shift_en<=1, go to ACC.
  - Otherwise data_ack<=0.
- ACC:
  - data_ack<=0.
  - Rows are counted only on cycles with row_valid=1. A cycle with row_valid=0 holds all state.
  - On a valid row: acc<=acc^shift_row if data_cache[ROWS-1]=1, else acc is unchanged. Then data_cache<=data_cache<<1 and row_cnt<=row_cnt+1.
  - On the valid row with row_cnt==ROWS-1:
    - key_out<=final value (acc xor the gated row).
    - key_valid<=1.
    - shift_en<=0.
    - go to DONE.
    - key_valid is therefore visible one cycle after the edge that samples the last row.
  - data_en is ignored in ACC.
- DONE:
  - key_valid holds and key_out is stable. row_valid and data_en are ignored, and shift_row is not accumulated.
  - On key_ready=1: key_valid<=0, go to IDLE.
  - key_ready already high on DONE entry is honoured on the first DONE cycle.
  - key_ready outside DONE is ignored.
- key_out keeps its last value after the handshake until the next block completes.
- Throughput: at most one row per clock. Minimum block time is 1 (IDLE latch) + ROWS + 1 (handshake) cycles.
- Width rules: XOR is bitwise over ROW_W with no carry. row_cnt never wraps within a block.

Test Plan (ROW_W=8, ROWS=4, CNT_W=3 unless noted):
- Basic hash: raw_data=4'b1011, then rows 0x01,0x02,0x04,0x08 on consecutive cycles → data_ack one-cycle pulse; key_out=0x0D; key_valid rises one cycle after the 4th row.
- Gapped rows: same data, row_valid pattern 1,0,0,1,1,0,1, with junk 0xFF on the invalid cycles → key_out=0x0D (invalid rows ignored).
- All-zero data: raw_data=4'b0000 with any rows → key_out=0x00 and key_valid=1.
- Backpressure: hold key_ready=0 for 5 cycles in DONE while row_valid=1 and data_en=1 → key_valid and key_out stay stable, no new data_ack; key_ready=1 → key_valid=0 next cycle, IDLE.
- Reset mid-block: assert rst after 2 rows → all outputs 0 immediately; a new block with raw_data=4'b1111 and rows 0x11,0x22,0x44,0x88 → key_out=0xFF.
- Default params: ROW_W=3072, ROWS=4096, raw_data all ones, rows = successive left shifts of a single-bit seed → key_out matches the golden model XOR.

Source files
------------

// File: rtl/toeplitz_sum_single.sv
// Toeplitz hash accumulator: latches one raw block, XOR-folds the incoming
// generator rows selected by the raw bits (MSB first) and hands the key downstream.
module toeplitz_sum_single #(
    parameter int ROW_W = 3072,
    parameter int ROWS  = 4096,
    parameter int CNT_W = 13
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [ROWS-1:0]  raw_data,
    input  logic             data_en,
    output logic             data_ack,
    output logic             shift_en,
    input  logic             row_valid,
    input  logic [ROW_W-1:0] shift_row,
    output logic [ROW_W-1:0] key_out,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [ROW_W-1:0]   acc_r;
    logic [ROW_W-1:0]   acc_nxt_s;
    logic [ROWS-1:0]    data_cache_r;
    logic [ROWS-1:0]    data_cache_nxt_s;
    logic [CNT_W-1:0]   row_cnt_r;
    logic [CNT_W-1:0]   row_cnt_nxt_s;
    logic [ROW_W-1:0]   key_out_r;
    logic [ROW_W-1:0]   key_out_nxt_s;
    logic               key_valid_r;
    logic               key_valid_nxt_s;
    logic               data_ack_r;
    logic               data_ack_nxt_s;
    logic               shift_en_r;
    logic               shift_en_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic [ROW_W-1:0]   gated_row_s;

    // Row contribution: the row only counts when the current raw bit is set
    always_comb begin
        gated_row_s = {ROW_W{1'b0}};
        if (data_cache_r[ROWS-1]) begin
            gated_row_s = shift_row;
        end else begin
            gated_row_s = {ROW_W{1'b0}};
        end
    end

    // Next-state and next-register computation for the block controller
    always_comb begin
        state_nxt_s      = state_r;
        acc_nxt_s        = acc_r;
        data_cache_nxt_s = data_cache_r;
        row_cnt_nxt_s    = row_cnt_r;
        key_out_nxt_s    = key_out_r;
        key_valid_nxt_s  = key_valid_r;
        data_ack_nxt_s   = 1'b0;
        shift_en_nxt_s   = shift_en_r;
        busy_nxt_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                acc_nxt_s       = {ROW_W{1'b0}};
                row_cnt_nxt_s   = {CNT_W{1'b0}};
                key_valid_nxt_s = 1'b0;
                shift_en_nxt_s  = 1'b0;
                if (data_en) begin
                    data_cache_nxt_s = raw_data;
                    data_ack_nxt_s   = 1'b1;
                    shift_en_nxt_s   = 1'b1;
                    state_nxt_s      = ST_ACC;
                end else begin
                    data_ack_nxt_s   = 1'b0;
                end
            end

            ST_ACC: begin
                data_ack_nxt_s = 1'b0;
                // Idle cycles from the generator leave every register untouched
                if (row_valid) begin
                    acc_nxt_s        = acc_r ^ gated_row_s;
                    data_cache_nxt_s = {data_cache_r[ROWS-2:0], 1'b0};
                    row_cnt_nxt_s    = row_cnt_r + CNT_ONE;
                    if (row_cnt_r == LAST_ROW) begin
                        key_out_nxt_s   = acc_r ^ gated_row_s;
                        key_valid_nxt_s = 1'b1;
                        shift_en_nxt_s  = 1'b0;
                        state_nxt_s     = ST_DONE;
                    end else begin
                        shift_en_nxt_s  = 1'b1;
                    end
                end else begin
                    shift_en_nxt_s = shift_en_r;
                end
            end

            ST_DONE: begin
                shift_en_nxt_s = 1'b0;
                if (key_ready) begin
                    key_valid_nxt_s = 1'b0;
                    acc_nxt_s       = {ROW_W{1'b0}};
                    row_cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s     = ST_IDLE;
                end else begin
                    key_valid_nxt_s = 1'b1;
                end
            end

            default: begin
                acc_nxt_s        = {ROW_W{1'b0}};
                data_cache_nxt_s = {ROWS{1'b0}};
                row_cnt_nxt_s    = {CNT_W{1'b0}};
                key_valid_nxt_s  = 1'b0;
                shift_en_nxt_s   = 1'b0;
                state_nxt_s      = ST_IDLE;
            end
        endcase

        if ((state_nxt_s == ST_ACC) || (state_nxt_s == ST_DONE)) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            acc_r        <= {ROW_W{1'b0}};
            data_cache_r <= {ROWS{1'b0}};
            row_cnt_r    <= {CNT_W{1'b0}};
            key_out_r    <= {ROW_W{1'b0}};
            key_valid_r  <= 1'b0;
            data_ack_r   <= 1'b0;
            shift_en_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            acc_r        <= acc_nxt_s;
            data_cache_r <= data_cache_nxt_s;
            row_cnt_r    <= row_cnt_nxt_s;
            key_out_r    <= key_out_nxt_s;
            key_valid_r  <= key_valid_nxt_s;
            data_ack_r   <= data_ack_nxt_s;
            shift_en_r   <= shift_en_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign data_ack  = data_ack_r;
    assign shift_en  = shift_en_r;
    assign key_out   = key_out_r;
    assign key_valid = key_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_toeplitz_sum_single.sv
// Self-checking bench: small instance driven by directed and random blocks,
// plus one default-size instance hashing a full block of shifted single-bit rows.
module tb_toeplitz_sum_single;

    localparam int SW = 8;
    localparam int SR = 4;
    localparam int SC = 3;
    localparam int BW = 3072;
    localparam int BR = 4096;
    localparam int BC = 13;

    typedef logic [SW-1:0] rows_t [SR];
    typedef int            gaps_t [SR];

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic          rst;
    logic [SR-1:0] raw_data;
    logic          data_en, data_ack, shift_en, row_valid, key_valid, key_ready, busy;
    logic [SW-1:0] shift_row, key_out;

    logic [BR-1:0] b_raw_data;
    logic          b_data_en, b_data_ack, b_shift_en, b_row_valid, b_key_valid, b_key_ready, b_busy;
    logic [BW-1:0] b_shift_row, b_key_out;

    int n_checks = 0;
    int n_fail   = 0;

    toeplitz_sum_single #(.ROW_W(SW), .ROWS(SR), .CNT_W(SC)) dut (
        .clk_in(clk_in), .rst(rst), .raw_data(raw_data), .data_en(data_en),
        .data_ack(data_ack), .shift_en(shift_en), .row_valid(row_valid),
        .shift_row(shift_row), .key_out(key_out), .key_valid(key_valid),
        .key_ready(key_ready), .busy(busy)
    );

    toeplitz_sum_single #(.ROW_W(BW), .ROWS(BR), .CNT_W(BC)) dut_big (
        .clk_in(clk_in), .rst(rst), .raw_data(b_raw_data), .data_en(b_data_en),
        .data_ack(b_data_ack), .shift_en(b_shift_en), .row_valid(b_row_valid),
        .shift_row(b_shift_row), .key_out(b_key_out), .key_valid(b_key_valid),
        .key_ready(b_key_ready), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Reference hash: XOR of every row whose raw bit (MSB first) is set
    function automatic logic [SW-1:0] ref_hash(input logic [SR-1:0] raw, input rows_t rows);
        logic [SW-1:0] h;
        h = '0;
        for (int i = 0; i < SR; i++) begin
            if (raw[SR-1-i]) h = h ^ rows[i];
        end
        return h;
    endfunction

    task automatic run_block(input logic [SR-1:0] raw, input rows_t rows, input gaps_t gaps,
                             input int ready_delay, input logic junk_ff,
                             output logic [SW-1:0] key_seen);
        logic [SW-1:0] exp;
        exp       = ref_hash(raw, rows);
        raw_data  = raw;
        data_en   = 1'b1;
        row_valid = 1'($urandom);
        shift_row = SW'($urandom);
        key_ready = 1'($urandom);
        tick();
        check_eq("ack_pulse", {63'd0, data_ack}, 64'd1);
        check_eq("shift_en_on", {63'd0, shift_en}, 64'd1);
        check_eq("busy_acc", {63'd0, busy}, 64'd1);
        raw_data = SR'($urandom);
        data_en  = 1'($urandom);
        for (int i = 0; i < SR; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                row_valid = 1'b0;
                shift_row = junk_ff ? 8'hFF : SW'($urandom);
                tick();
                check_eq("gap_ack", {63'd0, data_ack}, 64'd0);
                check_eq("gap_kv", {63'd0, key_valid}, 64'd0);
                check_eq("gap_shift_en", {63'd0, shift_en}, 64'd1);
            end
            row_valid = 1'b1;
            shift_row = rows[i];
            key_ready = 1'($urandom);
            tick();
            if (i < SR - 1) begin
                check_eq("mid_kv", {63'd0, key_valid}, 64'd0);
                check_eq("mid_ack", {63'd0, data_ack}, 64'd0);
            end
        end
        check_eq("kv_after_last", {63'd0, key_valid}, 64'd1);
        check_eq("key_val", {56'd0, key_out}, {56'd0, exp});
        check_eq("shift_en_off", {63'd0, shift_en}, 64'd0);
        row_valid = 1'b1;
        shift_row = SW'($urandom);
        data_en   = 1'b1;
        raw_data  = SR'($urandom);
        key_ready = (ready_delay == 0);
        for (int d = 0; d < ready_delay; d++) begin
            tick();
            check_eq("bp_kv", {63'd0, key_valid}, 64'd1);
            check_eq("bp_key", {56'd0, key_out}, {56'd0, exp});
            check_eq("bp_ack", {63'd0, data_ack}, 64'd0);
            check_eq("bp_busy", {63'd0, busy}, 64'd1);
        end
        key_ready = 1'b1;
        tick();
        check_eq("hs_kv", {63'd0, key_valid}, 64'd0);
        check_eq("hs_busy", {63'd0, busy}, 64'd0);
        check_eq("hs_ack", {63'd0, data_ack}, 64'd0);
        data_en   = 1'b0;
        key_ready = 1'b0;
        row_valid = 1'b0;
        tick();
        check_eq("idle_key_hold", {56'd0, key_out}, {56'd0, exp});
        check_eq("idle_ack", {63'd0, data_ack}, 64'd0);
        key_seen = key_out;
    endtask

    initial begin
        rows_t         rows;
        gaps_t         gaps;
        logic [SW-1:0] k;
        logic [BW-1:0] row_v, exp_b;

        rst = 1'b1;
        raw_data = '0; data_en = 1'b0; row_valid = 1'b0; shift_row = '0; key_ready = 1'b0;
        b_raw_data = '0; b_data_en = 1'b0; b_row_valid = 1'b0; b_shift_row = '0; b_key_ready = 1'b0;
        #12;
        check_eq("rst_key", {56'd0, key_out}, 64'd0);
        check_eq("rst_kv", {63'd0, key_valid}, 64'd0);
        check_eq("rst_ack", {63'd0, data_ack}, 64'd0);
        check_eq("rst_shift_en", {63'd0, shift_en}, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic hash, back-to-back rows
        rows = '{8'h01, 8'h02, 8'h04, 8'h08};
        gaps = '{0, 0, 0, 0};
        run_block(4'b1011, rows, gaps, 1, 1'b1, k);
        check_eq("basic_0d", {56'd0, k}, 64'h0D);

        // Gapped rows: valid pattern 1,0,0,1,1,0,1 with 0xFF junk
        gaps = '{0, 2, 0, 1};
        run_block(4'b1011, rows, gaps, 0, 1'b1, k);
        check_eq("gapped_0d", {56'd0, k}, 64'h0D);

        // All-zero data
        rows = '{8'h5A, 8'hC3, 8'h7E, 8'h99};
        gaps = '{0, 1, 0, 0};
        run_block(4'b0000, rows, gaps, 2, 1'b0, k);
        check_eq("zero_key", {56'd0, k}, 64'h00);

        // Backpressure for 5 cycles
        rows = '{8'h01, 8'h02, 8'h04, 8'h08};
        gaps = '{0, 0, 0, 0};
        run_block(4'b1011, rows, gaps, 5, 1'b1, k);

        // Reset mid-block after two rows
        raw_data = 4'b1111; data_en = 1'b1;
        tick();
        data_en = 1'b0; row_valid = 1'b1; shift_row = 8'h11;
        tick();
        shift_row = 8'h22;
        tick();
        row_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("mrst_key", {56'd0, key_out}, 64'd0);
        check_eq("mrst_kv", {63'd0, key_valid}, 64'd0);
        check_eq("mrst_shift_en", {63'd0, shift_en}, 64'd0);
        check_eq("mrst_busy", {63'd0, busy}, 64'd0);
        check_eq("mrst_ack", {63'd0, data_ack}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_kv", {63'd0, key_valid}, 64'd0);
        rows = '{8'h11, 8'h22, 8'h44, 8'h88};
        run_block(4'b1111, rows, gaps, 1, 1'b0, k);
        check_eq("after_rst_ff", {56'd0, k}, 64'hFF);

        // Randomized blocks
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < SR; i++) begin
                rows[i] = SW'($urandom);
                gaps[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_block(SR'($urandom), rows, gaps, int'($urandom_range(0, 4)), 1'b0, k);
        end

        // Default-size instance: raw all ones, single-bit seed shifted left each row
        b_raw_data = '1;
        b_data_en  = 1'b1;
        tick();
        check_eq("big_ack", {63'd0, b_data_ack}, 64'd1);
        b_data_en = 1'b0;
        row_v = '0;
        row_v[0] = 1'b1;
        exp_b = '0;
        for (int i = 0; i < BR; i++) begin
            if (b_raw_data[BR-1-i]) exp_b = exp_b ^ row_v;
            b_row_valid = 1'b1;
            b_shift_row = row_v;
            tick();
            row_v = row_v << 1;
        end
        b_row_valid = 1'b0;
        check_eq("big_kv", {63'd0, b_key_valid}, 64'd1);
        check_eq("big_key_bit_errs", 64'($countones(b_key_out ^ exp_b)), 64'd0);
        b_key_ready = 1'b1;
        tick();
        check_eq("big_hs_kv", {63'd0, b_key_valid}, 64'd0);
        check_eq("big_hs_busy", {63'd0, b_busy}, 64'd0);
        b_key_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
